// File: rtl/mmio_char_led_periph.sv
// Data-bus slave for Ibex: byte-serialising character-buffer window, LED and STATUS registers.
// Define MMIO_CHAR_PERIPH_ERR_EN to report unmapped accesses and zero-enable LED writes on err_o.
module mmio_char_led_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h0003_8000,
  parameter int unsigned CHAR_DEPTH = 64,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned CHAR_AW    = $clog2(CHAR_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic               char_we_o,
  output logic [CHAR_AW-1:0] char_addr_o,
  output logic [7:0]         char_wdata_o,
  output logic [LED_W-1:0]   led_o
);

  localparam int unsigned        OW       = CHAR_AW + 1;
  localparam logic [OW-1:0]      LED_OFF  = OW'(CHAR_DEPTH);
  localparam logic [OW-1:0]      STAT_OFF = OW'(CHAR_DEPTH + 4);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              r_state, w_state_next;
  logic [CHAR_AW-3:0]  r_base;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [15:0]         r_cnt;
  logic [LED_W-1:0]    r_led;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [OW-1:0]       w_off;
  logic                w_sel, w_gnt, w_start;
  logic                w_is_char, w_is_led, w_is_stat;
  logic [1:0]          w_lane;
  logic [3:0]          w_be_left;
  logic [31:0]         w_rdata;
  logic                w_err;
  logic [LED_W-1:0]    w_led_next;

  // Decode: the window spans 2*CHAR_DEPTH bytes; the top offset bit splits chars from registers.
  assign w_sel     = req_i && (addr_i[31:CHAR_AW+1] == BASE_ADDR[31:CHAR_AW+1]);
  assign w_off     = addr_i[CHAR_AW:0];
  assign w_is_char = !w_off[CHAR_AW];
  assign w_is_led  = (w_off == LED_OFF);
  assign w_is_stat = (w_off == STAT_OFF);

  assign w_gnt   = w_sel && (r_state == S_IDLE);
  assign w_start = w_gnt && we_i && w_is_char && (be_i != 4'b0000);

  // Lowest pending lane is emitted first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_lane = 2'd0;
    if      (r_be[0]) w_lane = 2'd0;
    else if (r_be[1]) w_lane = 2'd1;
    else if (r_be[2]) w_lane = 2'd2;
    else if (r_be[3]) w_lane = 2'd3;
  end

  assign w_be_left = r_be & ~(4'b0001 << w_lane);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_next = S_BUSY;
      S_BUSY: if (w_be_left == 4'b0000) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    if (!we_i) begin
      if (w_is_led)  w_rdata[LED_W-1:0] = r_led;
      if (w_is_stat) w_rdata = {r_cnt, 15'b0, (r_state == S_BUSY)};
    end
`ifdef MMIO_CHAR_PERIPH_ERR_EN
    w_err = !(w_is_char || w_is_led || w_is_stat) ||
            (w_is_led && we_i && (be_i == 4'b0000));
`else
    w_err = 1'b0;
`endif
  end

  // Byte-lane masked LED update; lanes beyond LED_W fall off the end of the loop.
  always_comb begin
    w_led_next = r_led;
    if (w_gnt && we_i && w_is_led) begin
      for (int i = 0; i < int'(LED_W); i++) begin
        if (be_i[i/8]) w_led_next[i] = wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_cnt    <= '0;
      r_led    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_next;
      r_led    <= w_led_next;
      r_rvalid <= w_gnt;
      r_rdata  <= w_gnt ? w_rdata : '0;
      r_err    <= w_gnt && w_err;
      if (w_start) begin
        r_base  <= w_off[CHAR_AW-1:2];
        r_wdata <= wdata_i;
        r_be    <= be_i;
      end else if (r_state == S_BUSY) begin
        r_be  <= w_be_left;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign gnt_o        = w_gnt;
  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign led_o        = r_led;
  assign char_we_o    = (r_state == S_BUSY);
  assign char_addr_o  = char_we_o ? {r_base, w_lane} : '0;
  assign char_wdata_o = char_we_o ? r_wdata[{w_lane, 3'b000} +: 8] : 8'h00;

endmodule
